// File: rtl/ros_pkg.sv
// Shared types and default widths for the ring-oscillator measurement path and
// the register slave that exposes it.
package ros_pkg;

  localparam int ROS_WINDOW_W    = 24;
  localparam int ROS_CNT_W       = 32;
  localparam int ROS_SYNC_STAGES = 2;
  localparam int ROS_SEQ_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } ros_state_e;

endpackage

// File: rtl/ros_meas_ctrl_if.sv
// Control/status bundle between the sensor register slave (master) and the
// measurement controller (slave).
interface ros_meas_ctrl_if
  import ros_pkg::*;
#(
  parameter int WINDOW_W = ROS_WINDOW_W,
  parameter int CNT_W    = ROS_CNT_W
);

  logic                 start;
  logic                 clear;
  logic [WINDOW_W-1:0]  window_len;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic [ROS_SEQ_W-1:0] meas_seq;

  modport master (
    output start, clear, window_len,
    input  busy, done, count, overflow, meas_seq
  );

  modport slave (
    input  start, clear, window_len,
    output busy, done, count, overflow, meas_seq
  );

endinterface

// File: rtl/ros_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; the flops run continuously, independent of any consumer state.
module ros_sync_edge
  import ros_pkg::*;
#(
  parameter int SYNC_STAGES = ROS_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware shift chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ros_meas_ctrl.sv
// Ring-oscillator measurement controller: counts synchronized RO rising edges
// over a programmable window and publishes a saturating count with status.
module ros_meas_ctrl
  import ros_pkg::*;
#(
  parameter int WINDOW_W    = ROS_WINDOW_W,
  parameter int CNT_W       = ROS_CNT_W,
  parameter int SYNC_STAGES = ROS_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ro_in,
  ros_meas_ctrl_if.slave   bus
);

  ros_state_e           state, state_d;
  logic [WINDOW_W-1:0]  timer;
  logic [CNT_W-1:0]     cnt, cnt_d, count_q;
  logic                 ovf, ovf_d, overflow_q, done_q;
  logic [ROS_SEQ_W-1:0] seq_q;
  logic                 rise, accept, win_end;

  ros_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clock    (clock),
    .reset    (reset),
    .async_in (ro_in),
    .rise     (rise)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    win_end = 1'b0;
    cnt_d   = cnt;
    ovf_d   = ovf;

    // The counter parks at all-ones; an edge arriving there marks overflow.
    if (rise) begin
      if (&cnt) ovf_d = 1'b1;
      else      cnt_d = cnt + CNT_W'(1);
    end

    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_d = COUNT;
            accept  = 1'b1;
          end
        end
        COUNT: begin
          if (timer == WINDOW_W'(1)) begin
            state_d = IDLE;
            win_end = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer      <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      seq_q      <= '0;
    end else if (bus.clear) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (accept) begin
      timer  <= (bus.window_len == '0) ? WINDOW_W'(1) : bus.window_len;
      cnt    <= '0;
      ovf    <= 1'b0;
      done_q <= 1'b0;
    end else if (state == COUNT) begin
      timer <= timer - WINDOW_W'(1);
      cnt   <= cnt_d;
      ovf   <= ovf_d;
      // Publish the post-update value so an edge on the final cycle is counted.
      if (win_end) begin
        count_q    <= cnt_d;
        overflow_q <= ovf_d;
        done_q     <= 1'b1;
        seq_q      <= seq_q + ROS_SEQ_W'(1);
      end
    end
  end

  assign bus.busy     = (state == COUNT);
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.meas_seq = seq_q;

endmodule

// File: tb/tb_ros_meas_ctrl.sv
// Self-checking bench for ros_meas_ctrl: a default-width instance and a 4-bit
// counter instance for saturation, driven from a vector table plus corner cases.
module tb_ros_meas_ctrl;
  import ros_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ro    = 1'b0;
  int   ro_period = 0;
  int   ro_ph     = 0;

  always #5 clock = ~clock;

  ros_meas_ctrl_if                b0 ();
  ros_meas_ctrl_if #(.CNT_W(4))   b1 ();

  ros_meas_ctrl dut0 (
    .clock (clock),
    .reset (reset),
    .ro_in (ro),
    .bus   (b0)
  );

  ros_meas_ctrl #(.CNT_W(4)) dut1 (
    .clock (clock),
    .reset (reset),
    .ro_in (ro),
    .bus   (b1)
  );

  // Free-running RO model, changed away from the sampling edge.
  always @(negedge clock) begin
    if (ro_period == 0) begin
      ro    = 1'b0;
      ro_ph = 0;
    end else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro    = (ro_ph < ro_period / 2);
    end
  end

  typedef struct {
    int sel;
    int period;
    int wlen;
    int exp_cnt;
    bit exp_ovf;
    int exp_busy;
    int restart_at;
  } vec_t;

  typedef struct {
    int cnt;
    bit ovf;
    int seq;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   seq_model[2] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? b0.busy : b1.busy;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? b0.done : b1.done;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? b0.overflow : b1.overflow;
  endfunction
  function automatic logic [31:0] get_count(input int sel);
    return (sel == 0) ? b0.count : {28'd0, b1.count};
  endfunction
  function automatic logic [7:0] get_seq(input int sel);
    return (sel == 0) ? b0.meas_seq : b1.meas_seq;
  endfunction

  task automatic set_start(input int sel, input bit v, input int wlen);
    if (sel == 0) begin
      b0.start = v;
      if (v) b0.window_len = 24'(wlen);
    end else begin
      b1.start = v;
      if (v) b1.window_len = 24'(wlen);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   nb;
    exp_t e;
    ro_period = v.period;
    repeat (20) @(negedge clock);
    seq_model[v.sel] = (seq_model[v.sel] + 1) % 256;
    sb.push_back('{v.exp_cnt, v.exp_ovf, seq_model[v.sel]});
    set_start(v.sel, 1'b1, v.wlen);
    @(negedge clock);
    set_start(v.sel, 1'b0, 0);
    check("busy_rise", get_busy(v.sel), 1'b1);
    check("done_cleared_on_start", get_done(v.sel), 1'b0);
    nb = 0;
    while (get_busy(v.sel) && nb < 70000) begin
      nb++;
      set_start(v.sel, (nb == v.restart_at), 5);
      @(negedge clock);
    end
    set_start(v.sel, 1'b0, 0);
    check("busy_cycles", nb, v.exp_busy);
    check("done_at_busy_fall", get_done(v.sel), 1'b1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("count", get_count(v.sel), e.cnt);
      check("overflow", get_ovf(v.sel), e.ovf);
      check("meas_seq", get_seq(v.sel), e.seq);
    end
  endtask

  initial begin
    b0.start = 1'b0; b0.clear = 1'b0; b0.window_len = '0;
    b1.start = 1'b0; b1.clear = 1'b0; b1.window_len = '0;

    #1;
    check("rst_busy", b0.busy, 1'b0);
    check("rst_done", b0.done, 1'b0);
    check("rst_count", b0.count, 0);
    check("rst_overflow", b0.overflow, 1'b0);
    check("rst_meas_seq", b0.meas_seq, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    //              sel per win  cnt ovf busy restart
    vecs.push_back('{0, 10, 100, 10, 0, 100, -1});
    vecs.push_back('{0,  0,   0,  0, 0,   1, -1});
    vecs.push_back('{0,  4,  40, 10, 0,  40, -1});
    vecs.push_back('{0,  6,  30,  5, 0,  30, -1});
    vecs.push_back('{0,  2,  20, 10, 0,  20, -1});
    vecs.push_back('{0,  0,   5,  0, 0,   5, -1});
    vecs.push_back('{1,  2,  40, 15, 1,  40, -1});
    vecs.push_back('{1,  0,  10,  0, 0,  10, -1});
    vecs.push_back('{0, 10,  50,  5, 0,  50, 20});
    foreach (vecs[i]) run_vec(vecs[i]);

    // clear coincident with start in the middle of a window
    ro_period = 10;
    repeat (20) @(negedge clock);
    set_start(0, 1'b1, 100);
    @(negedge clock);
    set_start(0, 1'b0, 0);
    repeat (30) @(negedge clock);
    check("coll_busy_before", b0.busy, 1'b1);
    b0.clear = 1'b1;
    set_start(0, 1'b1, 5);
    @(negedge clock);
    b0.clear = 1'b0;
    set_start(0, 1'b0, 0);
    check("coll_busy", b0.busy, 1'b0);
    check("coll_done", b0.done, 1'b0);
    check("coll_count", b0.count, 0);
    check("coll_overflow", b0.overflow, 1'b0);
    check("coll_meas_seq", b0.meas_seq, seq_model[0]);
    repeat (10) @(negedge clock);
    check("coll_no_new_busy", b0.busy, 1'b0);
    check("coll_no_new_seq", b0.meas_seq, seq_model[0]);

    // async reset in the middle of a window, after a published nonzero result
    run_vec('{0, 10, 20, 2, 0, 20, -1});
    set_start(0, 1'b1, 100);
    @(negedge clock);
    set_start(0, 1'b0, 0);
    repeat (30) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", b0.busy, 1'b0);
    check("arst_done", b0.done, 1'b0);
    check("arst_count", b0.count, 0);
    check("arst_meas_seq", b0.meas_seq, 0);
    @(negedge clock);
    reset = 1'b0;
    seq_model[0] = 0;
    seq_model[1] = 0;
    run_vec('{0, 10, 100, 10, 0, 100, -1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ros_meas_ctrl.md
# ros_meas_ctrl

Measurement controller for a ring-oscillator reliability sensor. It counts rising edges of a pre-divided ring-oscillator output over a programmable window of system-clock cycles and publishes the result. It sits directly upstream of the AXI4-Lite sensor register slave: start, window length and clear arrive from slave registers, and count, status and sequence number are read back through them.

## Interface
Parameters:
- `WINDOW_W`, 24: width of the window-length input, in clock cycles.
- `CNT_W`, 32: width of the edge counter and result.
- `SYNC_STAGES`, 2: synchronizer depth on `ro_in`; minimum 2.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock, same as the AXI-Lite clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ro_in`  in  1  divided RO output, asynchronous to `clock`; frequency must be below clock/2.
- `start`  in  1  single-cycle pulse from the control-register write strobe.
- `clear`  in  1  single-cycle pulse; aborts the current measurement and clears the results.
- `window_len`  in  WINDOW_W  window length in clocks; sampled on an accepted `start`.
- `busy`  out  1  high while counting.
- `done`  out  1  sticky; result valid.
- `count`  out  CNT_W  last completed edge count.
- `overflow`  out  1  last completed count saturated.
- `meas_seq`  out  8  number of completed measurements, wraps modulo 256.

## Operation
- FSM states: IDLE, COUNT.
- IDLE to COUNT: on `start` with `clear` low. Same cycle:
  - latch `window_len`; a value of 0 is treated as 1;
  - zero the internal counter;
  - clear `done`.
- COUNT:
  - internal counter increments on each cycle where the edge detector fires;
  - window timer decrements each cycle;
  - on the last window cycle, return to IDLE.
- Window end, in one cycle:
  - `count` takes the internal counter value, including an edge detected on the last window cycle;
  - `overflow` takes the saturation flag;
  - `done` goes to 1;
  - `meas_seq` increments.
- Saturation: the internal counter stops at all-ones and sets the internal overflow flag. There is no wrap.
- `start` while in COUNT is ignored: no restart, no latch.
- `clear`, in any state:
  - go to IDLE;
  - `count`, `overflow` and `done` go to 0;
  - `meas_seq` is unchanged.
- `clear` has priority over a coincident `start` and over a coincident window end. The measurement is discarded.
- Edge detection: `ro_in` passes through `SYNC_STAGES` flops, then one more register. Edge = current synced value high and previous value low.
- An edge is attributed to the cycle in which the detector fires, not to the cycle of the `ro_in` transition.
- Synchronizer flops are not gated by the FSM. They run continuously.

## Timing
- Reset values: IDLE; `busy`, `done`, `overflow` = 0; `count` = 0; `meas_seq` = 0; synchronizer flops = 0.
- Reset mid-measurement: immediate return to reset values, with no result published.
- `busy` rises the cycle after `start`. It stays high for exactly N cycles, where N is the latched window length (minimum 1).
- `done`, `count` and `meas_seq` update on the clock edge that ends the N-th window cycle. They are visible the cycle `busy` falls.
- `count` holds the previous result throughout COUNT. It is never a partial value.
- Detector latency: a `ro_in` rise is seen by the detector `SYNC_STAGES`+1 clocks later.
- Back-to-back operation: a `start` in the first IDLE cycle after `done` is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `ros_pkg`:
  - state enum `ros_state_e` (IDLE, COUNT);
  - default localparams for `WINDOW_W`, `CNT_W`, `SYNC_STAGES`;
  - shared with the register slave for field widths.
- Sub-module `ros_sync_edge`:
  - parameterised synchronizer plus rising-edge detector;
  - `clock`/`reset`, `async_in`, `rise` out;
  - reused for other sensor inputs.
- Top module: FSM, window timer, saturating counter, result and status registers.

## Test plan
- Basic count: `ro_in` period 10 clocks (5 high / 5 low); `start` with `window_len`=100 -> `busy` high 100 cycles; then `count`=10, `done`=1, `overflow`=0, `meas_seq`=1.
- Zero window: `window_len`=0, `ro_in` held 0 -> `busy` high 1 cycle, `count`=0, `done`=1, `meas_seq` increments.
- Saturation: `CNT_W`=4, `ro_in` toggling every clock, `window_len`=40 -> `count`=15, `overflow`=1; a following measurement with `ro_in` idle gives `count`=0, `overflow`=0.
- Ignored restart: `start` (`window_len`=50) then a second `start` (`window_len`=5) 20 cycles later -> `busy` lasts 50 cycles total and `meas_seq` increments once.
- Clear/start collision: `clear` and `start` in the same cycle mid-COUNT -> IDLE next cycle, `done`=0, `count`=0, `meas_seq` unchanged, no new measurement.
- Async reset mid-COUNT: assert `reset` between clock edges -> all outputs at reset values immediately; after release, a `start` with `window_len`=100 and `ro_in` period 10 -> `count`=10, `meas_seq`=1.
